// File: rtl/mem_word_dumper.sv
// Streams a block of memory words to the UART transmitter, MSB byte first.
// Optional DUMP_CHECKSUM_EN appends an XOR checksum byte after the data.
module mem_word_dumper #(
  parameter int len_data      = 32,
  parameter int len_addr      = 8,
  parameter int NBIT_DATA_LEN = 8
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     start,
  input  logic [len_addr-1:0]      base_addr,
  input  logic [len_addr-1:0]      num_words,
  output logic                     mem_rd_en,
  output logic [len_addr-1:0]      mem_addr,
  input  logic [len_data-1:0]      mem_data,
  output logic                     tx_start,
  output logic [NBIT_DATA_LEN-1:0] tx_data,
  input  logic                     tx_done_tick,
  output logic                     busy,
  output logic                     done
);

  localparam int BYTES = len_data / NBIT_DATA_LEN;
  localparam int BCW   = (BYTES > 1) ? $clog2(BYTES) : 1;
  localparam logic [BCW-1:0] LAST_BYTE = BCW'(BYTES - 1);

  typedef enum logic [2:0] {
    S_IDLE,
    S_READ,
    S_LOAD,
    S_SEND,
    S_WAIT_TX,
`ifdef DUMP_CHECKSUM_EN
    S_CSUM_SEND,
    S_CSUM_WAIT,
`endif
    S_FIN
  } state_t;

`ifdef DUMP_CHECKSUM_EN
  localparam state_t S_TAIL = S_CSUM_SEND;
`else
  localparam state_t S_TAIL = S_FIN;
`endif

  state_t                     state_q, state_d;
  logic [len_addr-1:0]        addr_q;
  logic [len_addr-1:0]        words_left;
  logic [len_data-1:0]        shift_q;
  logic [BCW-1:0]             byte_cnt;
  logic                       last_byte, last_word;
  logic [NBIT_DATA_LEN-1:0]   top_byte;
`ifdef DUMP_CHECKSUM_EN
  logic [NBIT_DATA_LEN-1:0]   csum_q;
`endif

  assign top_byte  = shift_q[len_data-1 -: NBIT_DATA_LEN];
  assign last_byte = (byte_cnt == LAST_BYTE);
  assign last_word = (words_left == len_addr'(1));
  assign mem_addr  = addr_q;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) state_q <= S_IDLE;
    else        state_q <= state_d;
  end

  always_comb begin
    state_d   = state_q;
    mem_rd_en = 1'b0;
    tx_start  = 1'b0;
    busy      = 1'b0;
    done      = 1'b0;
    tx_data   = top_byte;
    case (state_q)
      S_IDLE:    if (start) state_d = (num_words == '0) ? S_TAIL : S_READ;
      S_READ: begin
        busy      = 1'b1;
        mem_rd_en = 1'b1;
        state_d   = S_LOAD;
      end
      S_LOAD: begin
        busy    = 1'b1;
        state_d = S_SEND;
      end
      S_SEND: begin
        busy     = 1'b1;
        tx_start = 1'b1;
        state_d  = S_WAIT_TX;
      end
      S_WAIT_TX: begin
        busy = 1'b1;
        if (tx_done_tick) begin
          if (!last_byte)      state_d = S_SEND;
          else if (!last_word) state_d = S_READ;
          else                 state_d = S_TAIL;
        end
      end
`ifdef DUMP_CHECKSUM_EN
      S_CSUM_SEND: begin
        busy     = 1'b1;
        tx_start = 1'b1;
        tx_data  = csum_q;
        state_d  = S_CSUM_WAIT;
      end
      S_CSUM_WAIT: begin
        busy    = 1'b1;
        tx_data = csum_q;
        if (tx_done_tick) state_d = S_FIN;
      end
`endif
      S_FIN: begin
        done    = 1'b1;
        state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  // Address/word bookkeeping advances only when the last byte of a word retires.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      addr_q     <= '0;
      words_left <= '0;
      shift_q    <= '0;
      byte_cnt   <= '0;
    end else begin
      case (state_q)
        S_IDLE: if (start) begin
          addr_q     <= base_addr;
          words_left <= num_words;
        end
        S_LOAD: begin
          shift_q  <= mem_data;
          byte_cnt <= '0;
        end
        S_WAIT_TX: if (tx_done_tick) begin
          shift_q  <= shift_q << NBIT_DATA_LEN;
          byte_cnt <= byte_cnt + BCW'(1);
          if (last_byte) begin
            words_left <= words_left - len_addr'(1);
            addr_q     <= addr_q + len_addr'(1);
          end
        end
        default: ;
      endcase
    end
  end

`ifdef DUMP_CHECKSUM_EN
  always_ff @(posedge clk or negedge reset) begin
    if (!reset)                          csum_q <= '0;
    else if (state_q == S_IDLE && start) csum_q <= '0;
    else if (state_q == S_SEND)          csum_q <= csum_q ^ top_byte;
  end
`endif

endmodule

// File: tb/tb_mem_word_dumper.sv
// Directed bench for mem_word_dumper: registered memory model plus a UART model
// that returns tx_done_tick 20 cycles after every tx_start.
module tb_mem_word_dumper;
  logic        clk = 1'b0;
  logic        reset, start;
  logic [7:0]  base_addr, num_words;
  logic        mem_rd_en;
  logic [7:0]  mem_addr;
  logic [31:0] mem_data;
  logic        tx_start;
  logic [7:0]  tx_data;
  logic        tx_done_tick;
  logic        uart_tick = 1'b0;
  logic        spur_tick = 1'b0;
  logic        busy, done;

  logic [31:0] mem [256];
  int          checks = 0, failures = 0;
  logic [7:0]  tx_q[$], rd_q[$], exp_q[$];
  int          done_cnt = 0, stable_err = 0, wait_cnt = 0;
  logic [7:0]  cur_byte = 8'h00;

  assign tx_done_tick = uart_tick | spur_tick;

  mem_word_dumper dut (
    .clk(clk), .reset(reset), .start(start), .base_addr(base_addr),
    .num_words(num_words), .mem_rd_en(mem_rd_en), .mem_addr(mem_addr),
    .mem_data(mem_data), .tx_start(tx_start), .tx_data(tx_data),
    .tx_done_tick(tx_done_tick), .busy(busy), .done(done)
  );

  always #5 clk = ~clk;

  always @(posedge clk) if (mem_rd_en) mem_data <= mem[mem_addr];

  // UART model and bus monitor, sampled mid-cycle.
  always @(negedge clk) begin
    uart_tick = 1'b0;
    if (!reset) wait_cnt = 0;
    else if (tx_start) begin
      tx_q.push_back(tx_data);
      cur_byte = tx_data;
      wait_cnt = 20;
    end else if (wait_cnt > 0) begin
      if (tx_data !== cur_byte) stable_err++;
      wait_cnt--;
      if (wait_cnt == 0) uart_tick = 1'b1;
    end
    if (mem_rd_en) rd_q.push_back(mem_addr);
    if (done) done_cnt++;
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic chk_stream(input string tag);
    chk({tag, "_nbytes"}, tx_q.size(), exp_q.size());
    for (int i = 0; i < exp_q.size() && i < tx_q.size(); i++)
      chk($sformatf("%s_byte%0d", tag, i), tx_q[i], exp_q[i]);
  endtask

  task automatic add_csum();
`ifdef DUMP_CHECKSUM_EN
    logic [7:0] x;
    x = 8'h00;
    foreach (exp_q[i]) x ^= exp_q[i];
    exp_q.push_back(x);
`endif
  endtask

  task automatic clear_mon();
    tx_q.delete(); rd_q.delete(); exp_q.delete();
    done_cnt = 0; stable_err = 0;
  endtask

  task automatic start_dump(input logic [7:0] b, input logic [7:0] n);
    @(negedge clk);
    base_addr = b; num_words = n; start = 1'b1;
    @(posedge clk);
    #1 start = 1'b0;
  endtask

  task automatic wait_done(input int max);
    int n;
    n = 0;
    while (done !== 1'b1 && n < max) begin
      @(negedge clk);
      n++;
    end
    chk("done_seen", done, 1'b1);
  endtask

  initial begin
    reset = 1'b1; start = 1'b0; base_addr = 8'h00; num_words = 8'h00;
    foreach (mem[i]) mem[i] = 32'h0;
    mem[8'h10] = 32'h12345678;
    mem[8'hFE] = 32'hAABBCCDD;
    mem[8'hFF] = 32'h01020304;
    mem[8'h00] = 32'hDEADBEEF;
    mem[8'h20] = 32'h11223344;
    mem[8'h21] = 32'h55667788;
    mem[8'h30] = 32'hCAFEF00D;
    #2 reset = 1'b0;
    repeat (3) @(negedge clk);
    chk("rst_busy", busy, 1'b0);
    chk("rst_done", done, 1'b0);
    chk("rst_rd_en", mem_rd_en, 1'b0);
    chk("rst_tx_start", tx_start, 1'b0);
    chk("rst_mem_addr", mem_addr, 8'h00);
    chk("rst_tx_data", tx_data, 8'h00);
    reset = 1'b1;

    // Single word, latency
    clear_mon();
    start_dump(8'h10, 8'h01);
    @(negedge clk);
    chk("t1_read_en", mem_rd_en, 1'b1);
    chk("t1_read_addr", mem_addr, 8'h10);
    chk("t1_busy", busy, 1'b1);
    @(negedge clk);
    chk("t1_load_rd_en", mem_rd_en, 1'b0);
    chk("t1_load_tx_start", tx_start, 1'b0);
    @(negedge clk);
    chk("t1_first_tx_start", tx_start, 1'b1);
    chk("t1_first_tx_data", tx_data, 8'h12);
    wait_done(300);
    chk("t1_fin_busy", busy, 1'b0);
    repeat (3) @(negedge clk);
    chk("t1_done_cnt", done_cnt, 1);
    chk("t1_nreads", rd_q.size(), 1);
    if (rd_q.size() > 0) chk("t1_rd0", rd_q[0], 8'h10);
    exp_q = '{8'h12, 8'h34, 8'h56, 8'h78};
    add_csum();
    chk_stream("t1");
    chk("t1_tx_stable", stable_err, 0);

    // Multi-word with address wrap, spurious ticks, start during WAIT_TX
    clear_mon();
    start_dump(8'hFE, 8'h03);
    spur_tick = 1'b1;
    @(posedge clk);
    @(posedge clk);
    #1 spur_tick = 1'b0;
    repeat (8) @(negedge clk);
    start = 1'b1; base_addr = 8'h40; num_words = 8'h05;
    @(negedge clk);
    start = 1'b0;
    wait_done(2000);
    repeat (3) @(negedge clk);
    chk("t2_done_cnt", done_cnt, 1);
    chk("t2_nreads", rd_q.size(), 3);
    if (rd_q.size() == 3) begin
      chk("t2_rd0", rd_q[0], 8'hFE);
      chk("t2_rd1", rd_q[1], 8'hFF);
      chk("t2_rd2", rd_q[2], 8'h00);
    end
    exp_q = '{8'hAA, 8'hBB, 8'hCC, 8'hDD, 8'h01, 8'h02, 8'h03, 8'h04,
              8'hDE, 8'hAD, 8'hBE, 8'hEF};
    add_csum();
    chk_stream("t2");
    chk("t2_tx_stable", stable_err, 0);

    // Zero length; a start in the FIN cycle must be ignored
    clear_mon();
    start_dump(8'h55, 8'h00);
`ifdef DUMP_CHECKSUM_EN
    wait_done(300);
`else
    @(negedge clk);
    chk("t3_done_next", done, 1'b1);
`endif
    chk("t3_fin_busy", busy, 1'b0);
    start = 1'b1; base_addr = 8'h30; num_words = 8'h01;
    @(posedge clk);
    #1 start = 1'b0;
    @(negedge clk);
    chk("t3_fin_start_busy", busy, 1'b0);
    chk("t3_fin_start_rd", mem_rd_en, 1'b0);
    repeat (3) @(negedge clk);
    chk("t3_nreads", rd_q.size(), 0);
    chk("t3_done_cnt", done_cnt, 1);
    exp_q.delete();
    add_csum();
    chk_stream("t3");

    // Reset during the 2nd byte of the first word, then a fresh dump
    clear_mon();
    start_dump(8'h20, 8'h02);
    begin
      int n;
      n = 0;
      while (tx_q.size() < 2 && n < 300) begin
        @(negedge clk);
        n++;
      end
    end
    chk("t4_second_byte_seen", tx_q.size(), 2);
    repeat (5) @(negedge clk);
    done_cnt = 0;
    #2 reset = 1'b0;
    #1;
    chk("t4_abort_busy", busy, 1'b0);
    chk("t4_abort_tx_start", tx_start, 1'b0);
    chk("t4_abort_rd_en", mem_rd_en, 1'b0);
    chk("t4_abort_done", done, 1'b0);
    chk("t4_abort_mem_addr", mem_addr, 8'h00);
    chk("t4_abort_tx_data", tx_data, 8'h00);
    repeat (3) @(negedge clk);
    reset = 1'b1;
    repeat (2) @(negedge clk);
    chk("t4_abort_no_done", done_cnt, 0);
    clear_mon();
    start_dump(8'h30, 8'h01);
    wait_done(300);
    repeat (3) @(negedge clk);
    chk("t4_done_cnt", done_cnt, 1);
    chk("t4_nreads", rd_q.size(), 1);
    if (rd_q.size() > 0) chk("t4_rd0", rd_q[0], 8'h30);
    exp_q = '{8'hCA, 8'hFE, 8'hF0, 8'h0D};
    add_csum();
    chk_stream("t4");

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
